t_stream_reader: RTL and testbench



---
 rtl/t_stream_reader_pkg.sv | 38 +++
 rtl/t_stream_reader_if.sv | 34 +++
 rtl/t_stream_reader_word_fifo2.sv | 66 ++++++
 rtl/t_stream_reader.sv | 152 +++++++++++++++
 tb/tb_t_stream_reader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t_stream_reader_pkg.sv
// Shared definitions for the T-sequence SRAM read path: widths, FSM encoding
// and small helpers used by the reader and its word FIFO.
package t_stream_reader_pkg;

    localparam int SRAM_WORD   = 256;
    localparam int SRAM_ADDR_W = 10;
    localparam int T_PER_WORD  = 7;
    localparam int SLOT_W      = 36;
    localparam int LEN_W       = 13;

    // Slot index within a word (0..T_PER_WORD-1).
    localparam int SLOT_IDX_W  = 3;
    // Word counter width: ceil((2^LEN_W-1)/T_PER_WORD) = 1171 fits in 11 bits.
    localparam int WCNT_W      = LEN_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of SRAM words holding len slots: ceil(len / T_PER_WORD).
    function automatic logic [WCNT_W-1:0] words_for_len(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] padded;
        logic [LEN_W:0] quot;
        padded = {1'b0, len} + (LEN_W+1)'(T_PER_WORD - 1);
        quot   = padded / (LEN_W+1)'(T_PER_WORD);
        return quot[WCNT_W-1:0];
    endfunction

    // Slot k of a packed word; bits above SLOT_W*T_PER_WORD are never selected.
    function automatic logic [SLOT_W-1:0] slot_of(input logic [SRAM_WORD-1:0] w,
                                                  input logic [SLOT_IDX_W-1:0] k);
        return w[SLOT_W*int'(k) +: SLOT_W];
    endfunction

endpackage

// File: rtl/t_stream_reader_if.sv
// Bus bundle between the reader, the T-sequence SRAM and the PE-array feeder.
interface t_stream_reader_if;
    import t_stream_reader_pkg::*;

    // SRAM side: a read is requested in any cycle with sram_cen=0; sram_q
    // carries that word in the following cycle.
    logic                   sram_cen;
    logic                   sram_wen;
    logic [SRAM_ADDR_W-1:0] sram_a;
    logic [SRAM_WORD-1:0]   sram_q;

    // Stream side: a slot transfers on a cycle where out_valid & out_ready;
    // once out_valid is high, out_slot/out_last hold until that transfer, and
    // out_valid never depends on out_ready.
    logic                   out_valid;
    logic                   out_ready;
    logic [SLOT_W-1:0]      out_slot;
    logic                   out_last;

    modport master (
        output sram_cen, sram_wen, sram_a,
        input  sram_q,
        output out_valid, out_slot, out_last,
        input  out_ready
    );

    modport slave (
        input  sram_cen, sram_wen, sram_a,
        output sram_q,
        input  out_valid, out_slot, out_last,
        output out_ready
    );

endinterface

// File: rtl/t_stream_reader_word_fifo2.sv
// Two-entry word FIFO with flow-through: when empty, the word being pushed
// is already visible at the head, so a word returned by the SRAM can be
// consumed in the same cycle it arrives.
module t_word_fifo2
    import t_stream_reader_pkg::*;
#(
    parameter int W = SRAM_WORD
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         head_valid,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt_q;
    logic         empty;
    logic         store;
    logic         take;

    // Head selection and whether the push is stored or passes straight through.
    always_comb begin
        empty      = (cnt_q == 2'd0);
        head       = empty ? push_data : mem[rd_ptr];
        head_valid = !empty || push;
        store      = push && !(pop && empty);
        take       = pop && !empty;
        count      = cnt_q;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (take) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({store, take})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/t_stream_reader.sv
// T-sequence SRAM reader: fetches t_len slots starting at base_addr and
// streams them one per cycle with out_last on the final slot.
// Optional build macro SW_TREADER_STALL_CNT_EN adds the stall_cnt output.
module t_stream_reader
    import t_stream_reader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SRAM_ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]       t_len,
    t_stream_reader_if.master      bus,
    output logic                   busy,
    output logic                   done,
    output state_t                 dbg_state
`ifdef SW_TREADER_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    state_t                 state_q;
    state_t                 state_d;
    logic [SRAM_ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]       len_q;
    logic [WCNT_W-1:0]      words_q;
    logic [WCNT_W-1:0]      word_idx_q;
    logic                   rd_pend_q;
    logic [SLOT_IDX_W-1:0]  slot_idx_q;
    logic [LEN_W-1:0]       emitted_q;
    logic                   zero_done_q;

    logic [SRAM_WORD-1:0]   fifo_head;
    logic                   fifo_head_valid;
    logic [1:0]             fifo_cnt;

    logic                   active;
    logic                   accept;
    logic                   issue;
    logic                   last_read;
    logic                   final_slot;
    logic                   end_of_word;
    logic                   handshake;
    logic                   pop;

    // Next state plus the control strobes derived from the current state.
    always_comb begin
        state_d     = state_q;
        active      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        accept      = (state_q == ST_IDLE) && start && (t_len != '0);
        // Buffered words plus the word in flight must stay below two so the
        // FIFO can always absorb what the SRAM returns.
        issue       = (state_q == ST_FETCH) &&
                      (({1'b0, fifo_cnt} + {2'b00, rd_pend_q}) < 3'd2);
        last_read   = (word_idx_q == (words_q - WCNT_W'(1)));
        final_slot  = (emitted_q == (len_q - LEN_W'(1)));
        end_of_word = (slot_idx_q == SLOT_IDX_W'(T_PER_WORD - 1));
        handshake   = bus.out_valid && bus.out_ready;
        pop         = handshake && (end_of_word || final_slot);

        unique case (state_q)
            ST_IDLE:  if (accept)                  state_d = ST_FETCH;
            ST_FETCH: if (issue && last_read)      state_d = ST_DRAIN;
            ST_DRAIN: if (handshake && final_slot) state_d = ST_DONE;
            ST_DONE:                               state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job parameters, read/unpack counters and the zero-length done strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            words_q     <= '0;
            word_idx_q  <= '0;
            rd_pend_q   <= 1'b0;
            slot_idx_q  <= '0;
            emitted_q   <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= (state_q == ST_IDLE) && start && (t_len == '0);
            rd_pend_q   <= issue;
            if (accept) begin
                base_q     <= base_addr;
                len_q      <= t_len;
                words_q    <= words_for_len(t_len);
                word_idx_q <= '0;
                slot_idx_q <= '0;
                emitted_q  <= '0;
            end else begin
                if (issue) begin
                    word_idx_q <= word_idx_q + WCNT_W'(1);
                end
                if (handshake) begin
                    emitted_q  <= emitted_q + LEN_W'(1);
                    slot_idx_q <= pop ? '0 : slot_idx_q + SLOT_IDX_W'(1);
                end
            end
        end
    end

    t_word_fifo2 #(
        .W (SRAM_WORD)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept),
        .push       (rd_pend_q),
        .push_data  (bus.sram_q),
        .pop        (pop),
        .head       (fifo_head),
        .head_valid (fifo_head_valid),
        .count      (fifo_cnt)
    );

    // SRAM request, stream outputs and status; the address wraps naturally.
    always_comb begin
        bus.sram_cen  = !issue;
        bus.sram_wen  = 1'b1;
        bus.sram_a    = base_q + word_idx_q[SRAM_ADDR_W-1:0];
        bus.out_valid = active && fifo_head_valid;
        bus.out_slot  = bus.out_valid ? slot_of(fifo_head, slot_idx_q) : '0;
        bus.out_last  = bus.out_valid && final_slot;
        busy          = active;
        done          = (state_q == ST_DONE) || zero_done_q;
        dbg_state     = state_q;
    end

`ifdef SW_TREADER_STALL_CNT_EN
    // Backpressure cycle counter: cleared by a new job, saturating, held after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (accept) begin
            stall_cnt <= 16'h0000;
        end else if (bus.out_valid && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_t_stream_reader.sv
// Bench for t_stream_reader: SRAM model, expected-slot scoreboard fed from a
// plain arithmetic model of the packing, and a monitor on the stream side.
module tb_t_stream_reader;
    import t_stream_reader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                   start = 1'b0;
    logic [SRAM_ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]       t_len = '0;
    logic                   busy;
    logic                   done;
    state_t                 dbg_state;
`ifdef SW_TREADER_STALL_CNT_EN
    logic [15:0]            stall_cnt;
`endif

    t_stream_reader_if bus ();

    t_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .t_len     (t_len),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
`ifdef SW_TREADER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // ---------------- SRAM model ----------------
    logic [SRAM_WORD-1:0] sram_mem [1024];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            for (int j = 0; j < SRAM_WORD / 32; j++) begin
                sram_mem[i][j*32 +: 32] = $urandom();
            end
        end
        bus.sram_q = '0;
        forever begin
            @(posedge clk);
            if (!bus.sram_cen) bus.sram_q <= sram_mem[bus.sram_a];
        end
    end

    // ---------------- downstream ready driver ----------------
    int         ready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    logic [3:0] ready_pat  = 4'b1001;
    int         ready_ph   = 0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    bus.out_ready = ready_pat[3 - ready_ph];
                    ready_ph = (ready_ph + 1) % 4;
                end
                2: bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    // entry = {ends_word, last, slot}
    logic [SLOT_W+1:0]      exp_q[$];
    logic [SRAM_ADDR_W-1:0] exp_addr_q[$];

    int n_hs    = 0;
    int issued  = 0;
    int popped  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: slot i of the job lives in word base+i/7 (mod 1024), field i%7.
    task automatic push_job(input int base, input int len);
        logic [SRAM_WORD-1:0] wd;
        int nwords;
        nwords = (len + T_PER_WORD - 1) / T_PER_WORD;
        for (int w = 0; w < nwords; w++) begin
            exp_addr_q.push_back(SRAM_ADDR_W'((base + w) % 1024));
        end
        for (int i = 0; i < len; i++) begin
            wd = sram_mem[(base + i / T_PER_WORD) % 1024];
            exp_q.push_back({ (i % T_PER_WORD == T_PER_WORD - 1) || (i == len - 1),
                              (i == len - 1),
                              wd[SLOT_W*(i % T_PER_WORD) +: SLOT_W] });
        end
    endtask

    // ---------------- monitor ----------------
    logic              prev_stall = 1'b0;
    logic [SLOT_W-1:0] prev_slot;
    logic              prev_last;

    initial begin
        logic [SLOT_W+1:0]      ent;
        logic [SRAM_ADDR_W-1:0] ea;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                issued = 0;
                popped = 0;
            end else begin
                if (!bus.sram_cen) begin
                    issued++;
                    if (exp_addr_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_read: got addr %0d expected no read", bus.sram_a);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("read_addr", bus.sram_a, ea);
                    end
                    check("words_buffered_le2", 64'(issued - popped <= 2), 1);
                end
                if (prev_stall) begin
                    check("stall_valid_hold", bus.out_valid, 1);
                    check("stall_slot_hold", bus.out_slot, prev_slot);
                    check("stall_last_hold", bus.out_last, prev_last);
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_hs++;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_slot: got %0h expected no slot", bus.out_slot);
                    end else begin
                        ent = exp_q.pop_front();
                        check("slot_data", bus.out_slot, ent[SLOT_W-1:0]);
                        check("slot_last", bus.out_last, ent[SLOT_W]);
                        if (ent[SLOT_W+1]) popped++;
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_slot  = bus.out_slot;
                prev_last  = bus.out_last;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_job(input int base, input int len, input int mode, input int poke_cyc);
        int done_cyc;
        done_cyc   = -1;
        ready_mode = mode;
        push_job(base, len);
        @(posedge clk); #1;
        start = 1'b1; base_addr = SRAM_ADDR_W'(base); t_len = LEN_W'(len);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 10 * len + 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("first_read_cen", bus.sram_cen, 0);
                check("first_read_addr", bus.sram_a, 64'(base % 1024));
                check("busy_after_start", busy, 1);
            end
            if (c == 2) check("first_valid_cycle2", bus.out_valid, 1);
            if (c == poke_cyc) begin
                check("busy_at_poke", busy, 1);
                start = 1'b1; base_addr = 10'd200; t_len = 13'd3;
            end
            if (c == poke_cyc + 1) start = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        if (done_cyc < 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 10 * len + 30);
        end else begin
            check("busy_low_at_done", busy, 0);
            if (mode == 0) check("gapfree_done_cycle", 64'(done_cyc), 64'(len + 2));
        end
        #1;
        check("slots_outstanding", 64'(exp_q.size()), 0);
        check("reads_outstanding", 64'(exp_addr_q.size()), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", dbg_state, ST_IDLE);
    endtask

    task automatic run_zero_len();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd50; t_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_len_done", done, 1);
        check("zero_len_busy", busy, 0);
        check("zero_len_cen", bus.sram_cen, 1);
        @(negedge clk);
        check("zero_len_done_drop", done, 0);
        check("zero_len_state", dbg_state, ST_IDLE);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cen"}, bus.sram_cen, 1);
        check({tag, "_wen"}, bus.sram_wen, 1);
        check({tag, "_addr"}, bus.sram_a, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_last"}, bus.out_last, 0);
        check({tag, "_slot"}, bus.out_slot, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic run_reset_abort();
        int hs0;
        int waited;
        ready_mode = 0;
        push_job(700, 21);
        hs0 = n_hs;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd700; t_len = 13'd21;
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while ((n_hs - hs0) < 5 && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        check("reached_slot5", 64'(n_hs - hs0), 5);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        @(negedge clk);
        rst = 1'b0;

        run_job(5, 14, 0, -10);
        run_job(77, 10, 0, -10);
        run_job(300, 21, 1, -10);
        run_job(1023, 8, 0, -10);
        run_zero_len();
        run_job(400, 21, 0, 5);
        run_reset_abort();
        run_job(600, 9, 0, -10);
        for (int k = 0; k < 6; k++) begin
            run_job($urandom_range(0, 1023), $urandom_range(1, 40), $urandom_range(0, 2), -10);
        end
        run_job(1020, 35, 2, -10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected end before 1000000");
        $fatal(1, "watchdog");
    end

endmodule
